// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one finished functional-unit
// result per cycle and holds it in a registered broadcast slot until it is acknowledged.
module cdb_arbiter #(
  parameter int                 NREQ   = 5,
  parameter int                 TAG_W  = 8,
  parameter int                 DATA_W = 32,
  parameter logic [TAG_W-1:0]   NO_TAG = 8'h7F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [2:0]               cdb_src,
  input  logic                     cdb_ack,
  output logic [31:0]              conflict_cnt,
  output logic                     bad_tag
);

  localparam logic [3:0] NREQ_W4 = 4'(NREQ);
  localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

  logic [2:0]        rr_ptr_r;
  logic              cdb_valid_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [DATA_W-1:0] cdb_data_r;
  logic [2:0]        cdb_src_r;
  logic [31:0]       conflict_cnt_r;
  logic              bad_tag_r;

  logic              slot_free_s;
  logic              grant_found_s;
  logic [2:0]        grant_idx_s;
  logic [3:0]        scan_s;
  logic [NREQ-1:0]   req_ready_s;
  logic [TAG_W-1:0]  grant_tag_s;
  logic [DATA_W-1:0] grant_data_s;
  logic [3:0]        req_count_s;
  logic [2:0]        next_ptr_s;

  assign slot_free_s = (!cdb_valid_r || cdb_ack) && !flush;
  assign next_ptr_s  = (grant_idx_s == LAST_IDX) ? 3'd0 : grant_idx_s + 3'd1;

  // Scan requesters starting at rr_ptr, wrapping at NREQ-1, and keep the first hit.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    scan_s        = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      scan_s = {1'b0, rr_ptr_r} + 4'(k);
      if (scan_s >= NREQ_W4) begin
        scan_s = scan_s - NREQ_W4;
      end else begin
        scan_s = scan_s;
      end
      if (slot_free_s && !grant_found_s && req_valid[scan_s[2:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_s[2:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot grant plus the winner's tag/data; also counts concurrent requests.
  always_comb begin
    req_ready_s  = '0;
    grant_tag_s  = '0;
    grant_data_s = '0;
    req_count_s  = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      req_count_s = req_count_s + {3'b000, req_valid[i]};
      if (grant_found_s && (grant_idx_s == 3'(i))) begin
        req_ready_s[i] = 1'b1;
        grant_tag_s    = req_tag[i*TAG_W +: TAG_W];
        grant_data_s   = req_data[i*DATA_W +: DATA_W];
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // Broadcast slot and round-robin pointer; flush outranks both ack and grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= NO_TAG;
      cdb_data_r  <= '0;
      cdb_src_r   <= 3'd0;
      rr_ptr_r    <= 3'd0;
      bad_tag_r   <= 1'b0;
    end else if (flush) begin
      cdb_valid_r <= 1'b0;
    end else if (grant_found_s) begin
      rr_ptr_r <= next_ptr_s;
      if (grant_tag_s == NO_TAG) begin
        // Reserved tag: consume the request but never broadcast it.
        bad_tag_r <= 1'b1;
        if (cdb_ack) begin
          cdb_valid_r <= 1'b0;
        end else begin
          cdb_valid_r <= cdb_valid_r;
        end
      end else begin
        cdb_valid_r <= 1'b1;
        cdb_tag_r   <= grant_tag_s;
        cdb_data_r  <= grant_data_s;
        cdb_src_r   <= grant_idx_s;
      end
    end else if (cdb_ack) begin
      cdb_valid_r <= 1'b0;
    end else begin
      cdb_valid_r <= cdb_valid_r;
    end
  end

  // Saturating count of cycles with two or more requesters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_r <= 32'd0;
    end else if ((req_count_s >= 4'd2) && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 32'd1;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign req_ready    = req_ready_s;
  assign cdb_valid    = cdb_valid_r;
  assign cdb_tag      = cdb_tag_r;
  assign cdb_data     = cdb_data_r;
  assign cdb_src      = cdb_src_r;
  assign conflict_cnt = conflict_cnt_r;
  assign bad_tag      = bad_tag_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for grant/slot behaviour plus
// hand-written reset sequences; conflict count is modelled from the applied requests.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [4:0]   req_valid;
  logic [39:0]  req_tag;
  logic [159:0] req_data;
  logic [4:0]   req_ready;
  logic         cdb_valid;
  logic [7:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [2:0]   cdb_src;
  logic         cdb_ack;
  logic [31:0]  conflict_cnt;
  logic         bad_tag;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cnt_exp = 32'd0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .cdb_ack(cdb_ack),
    .conflict_cnt(conflict_cnt), .bad_tag(bad_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   valid;
    logic [39:0]  tag;
    logic [159:0] data;
    logic         ack;
    logic         flush;
    logic [4:0]   exp_ready;
    logic         exp_valid;
    logic         chk_slot;
    logic [7:0]   exp_tag;
    logic [31:0]  exp_data;
    logic [2:0]   exp_src;
    logic         exp_bad;
  } vec_t;

  vec_t vecs[$];

  localparam logic [39:0]  ALL_TAGS = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
  localparam logic [159:0] ALL_DATA = {32'd104, 32'd103, 32'd102, 32'd101, 32'd100};

  function automatic logic [39:0] lt(int idx, logic [7:0] t);
    return 40'(t) << (idx * 8);
  endfunction

  function automatic logic [159:0] ld(int idx, logic [31:0] d);
    return 160'(d) << (idx * 32);
  endfunction

  function automatic vec_t mk(logic [4:0] v, logic [39:0] t, logic [159:0] d, logic a, logic f,
                              logic [4:0] er, logic ev, logic ck, logic [7:0] et,
                              logic [31:0] ed, logic [2:0] es, logic eb);
    vec_t r;
    r.valid = v; r.tag = t; r.data = d; r.ack = a; r.flush = f;
    r.exp_ready = er; r.exp_valid = ev; r.chk_slot = ck; r.exp_tag = et;
    r.exp_data = ed; r.exp_src = es; r.exp_bad = eb;
    return r;
  endfunction

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if ($countones(req_valid) >= 2 && !rst) cnt_exp = cnt_exp + 32'd1;
    #1;
  endtask

  task automatic check_reset_state(string tagname);
    check({tagname, " cdb_valid"}, 160'(cdb_valid), 160'(1'b0));
    check({tagname, " cdb_tag"}, 160'(cdb_tag), 160'(8'h7F));
    check({tagname, " cdb_data"}, 160'(cdb_data), 160'(32'd0));
    check({tagname, " cdb_src"}, 160'(cdb_src), 160'(3'd0));
    check({tagname, " conflict_cnt"}, 160'(conflict_cnt), 160'(32'd0));
    check({tagname, " bad_tag"}, 160'(bad_tag), 160'(1'b0));
  endtask

  task automatic idle_inputs();
    req_valid = 5'd0; req_tag = 40'd0; req_data = 160'd0;
    cdb_ack = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Round robin from reset pointer 0, ack high, back-to-back.
    vecs.push_back(mk(5'h1F, ALL_TAGS, ALL_DATA, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b1, 8'h10, 32'd100, 3'd0, 1'b0));
    vecs.push_back(mk(5'h1F, ALL_TAGS, ALL_DATA, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b1, 8'h11, 32'd101, 3'd1, 1'b0));
    vecs.push_back(mk(5'h1F, ALL_TAGS, ALL_DATA, 1'b1, 1'b0, 5'b00100, 1'b1, 1'b1, 8'h12, 32'd102, 3'd2, 1'b0));
    vecs.push_back(mk(5'h1F, ALL_TAGS, ALL_DATA, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b1, 8'h13, 32'd103, 3'd3, 1'b0));
    vecs.push_back(mk(5'h1F, ALL_TAGS, ALL_DATA, 1'b1, 1'b0, 5'b10000, 1'b1, 1'b1, 8'h14, 32'd104, 3'd4, 1'b0));
    vecs.push_back(mk(5'h1F, ALL_TAGS, ALL_DATA, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b1, 8'h10, 32'd100, 3'd0, 1'b0));
    // Single requester: add offers tag 5, data -7.
    vecs.push_back(mk(5'b00100, lt(2, 8'h05), ld(2, 32'hFFFF_FFF9), 1'b1, 1'b0, 5'b00100, 1'b1, 1'b1, 8'h05, 32'hFFFF_FFF9, 3'd2, 1'b0));
    // Idle with ack: slot empties; ack on an empty slot is harmless.
    vecs.push_back(mk(5'd0, 40'd0, 160'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 1'b0));
    vecs.push_back(mk(5'd0, 40'd0, 160'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 1'b0));
    // Fill slot with add (pointer 3 -> wraps to 2), leaving pointer at 3.
    vecs.push_back(mk(5'b00100, lt(2, 8'h21), ld(2, 32'h21), 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 8'h21, 32'h21, 3'd2, 1'b0));
    // Backpressure: mul and lw waiting, ack low for 3 cycles.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(5'b01001, lt(3, 8'h33) | lt(0, 8'h30), ld(3, 32'h33) | ld(0, 32'h30), 1'b0, 1'b0,
                        5'b00000, 1'b1, 1'b1, 8'h21, 32'h21, 3'd2, 1'b0));
    vecs.push_back(mk(5'b01001, lt(3, 8'h33) | lt(0, 8'h30), ld(3, 32'h33) | ld(0, 32'h30), 1'b1, 1'b0,
                      5'b01000, 1'b1, 1'b1, 8'h33, 32'h33, 3'd3, 1'b0));
    vecs.push_back(mk(5'b00001, lt(0, 8'h30), ld(0, 32'h30), 1'b1, 1'b0, 5'b00001, 1'b1, 1'b1, 8'h30, 32'h30, 3'd0, 1'b0));
    // Flush with a valid slot and two requests; pointer must stay at 1.
    vecs.push_back(mk(5'b01010, lt(1, 8'h41) | lt(3, 8'h43), ld(1, 32'h41) | ld(3, 32'h43), 1'b0, 1'b1,
                      5'b00000, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 1'b0));
    vecs.push_back(mk(5'b01010, lt(1, 8'h41) | lt(3, 8'h43), ld(1, 32'h41) | ld(3, 32'h43), 1'b0, 1'b0,
                      5'b00010, 1'b1, 1'b1, 8'h41, 32'h41, 3'd1, 1'b0));
    // Reserved tag from mv: consumed, never broadcast, bad_tag sticks.
    vecs.push_back(mk(5'b10000, lt(4, 8'h7F), ld(4, 32'h99), 1'b1, 1'b0, 5'b10000, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 1'b1));
    vecs.push_back(mk(5'b10000, lt(4, 8'h7F), ld(4, 32'h99), 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 1'b1));
    // Pointer wrapped to 0: lw loads tag 3 / data 42 for the mid-broadcast reset.
    vecs.push_back(mk(5'b00001, lt(0, 8'h03), ld(0, 32'd42), 1'b1, 1'b0, 5'b00001, 1'b1, 1'b1, 8'h03, 32'd42, 3'd0, 1'b1));

    tick();
    tick();
    check("reset ready", 160'(req_ready), 160'(5'd0));
    check_reset_state("reset");
    rst = 1'b0;

    foreach (vecs[n]) begin
      req_valid = vecs[n].valid;
      req_tag   = vecs[n].tag;
      req_data  = vecs[n].data;
      cdb_ack   = vecs[n].ack;
      flush     = vecs[n].flush;
      #1;
      check($sformatf("vec%0d req_ready", n), 160'(req_ready), 160'(vecs[n].exp_ready));
      tick();
      check($sformatf("vec%0d cdb_valid", n), 160'(cdb_valid), 160'(vecs[n].exp_valid));
      if (vecs[n].chk_slot) begin
        check($sformatf("vec%0d cdb_tag", n), 160'(cdb_tag), 160'(vecs[n].exp_tag));
        check($sformatf("vec%0d cdb_data", n), 160'(cdb_data), 160'(vecs[n].exp_data));
        check($sformatf("vec%0d cdb_src", n), 160'(cdb_src), 160'(vecs[n].exp_src));
      end
      check($sformatf("vec%0d bad_tag", n), 160'(bad_tag), 160'(vecs[n].exp_bad));
      check($sformatf("vec%0d conflict_cnt", n), 160'(conflict_cnt), 160'(cnt_exp));
    end

    // Asynchronous reset in the middle of a cycle while the slot holds tag 3.
    idle_inputs();
    #3;
    rst = 1'b1;
    #1;
    cnt_exp = 32'd0;
    check_reset_state("midrst");
    tick();
    rst = 1'b0;

    // Pointer must be back at 0 after reset.
    req_valid = 5'h1F; req_tag = ALL_TAGS; req_data = ALL_DATA; cdb_ack = 1'b1;
    #1;
    check("post-reset req_ready", 160'(req_ready), 160'(5'b00001));
    tick();
    check("post-reset cdb_tag", 160'(cdb_tag), 160'(8'h10));
    check("post-reset cdb_valid", 160'(cdb_valid), 160'(1'b1));
    check("post-reset conflict_cnt", 160'(conflict_cnt), 160'(cnt_exp));
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
